// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter generator.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        TRAP = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_J   = 2'd2,
        SEL_JR  = 2'd3
    } sel_e;

    localparam int unsigned JIDX_W = 26;

endpackage

// File: rtl/pc_target_mux.sv
// Next-PC target selection: jump_reg > jump > branch > sequential, all arithmetic mod 2^ADDR_W.
module pc_target_mux
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [ADDR_W-1:0] pc_plus4_i,
    input  logic              branch_taken_i,
    input  logic [31:0]       branch_imm_i,
    input  logic              jump_i,
    input  logic [JIDX_W-1:0] jump_idx_i,
    input  logic              jump_reg_i,
    input  logic [ADDR_W-1:0] reg_target_i,
    output logic [ADDR_W-1:0] target_o
);

    // Region bits above the 28-bit jump field come from pc+4; empty when ADDR_W <= 28.
    localparam logic [ADDR_W-1:0] JHI_MASK = ~ADDR_W'(32'h0FFF_FFFF);

    sel_e sel;

    always_comb begin
        sel = SEL_SEQ;
        if (jump_reg_i)
            sel = SEL_JR;
        else if (jump_i)
            sel = SEL_J;
        else if (branch_taken_i)
            sel = SEL_BR;
    end

    always_comb begin
        target_o = pc_plus4_i;
        case (sel)
            SEL_BR:  target_o = pc_i + ADDR_W'({branch_imm_i, 2'b00});
            SEL_J:   target_o = (pc_plus4_i & JHI_MASK) | ADDR_W'({jump_idx_i, 2'b00});
            SEL_JR:  target_o = reg_target_i;
            default: target_o = pc_plus4_i;
        endcase
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: BOOT/RUN/HALT(/TRAP) FSM and PC register.
// Optional misaligned-target trap enabled by defining PC_GEN_TRAP_EN.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned        ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
    parameter logic [ADDR_W-1:0]  HALT_ADDR = ADDR_W'(64),
    parameter logic [ADDR_W-1:0]  TRAP_VEC  = ADDR_W'('h80)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [31:0]       branch_imm,
    input  logic              jump,
    input  logic [JIDX_W-1:0] jump_idx,
    input  logic              jump_reg,
    input  logic [ADDR_W-1:0] reg_target,
    input  logic              resume,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              pc_valid,
    output logic              halted,
    output logic              trap
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] target;

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + ADDR_W'(4);
    assign pc_valid = (state_q == RUN);
    assign halted   = (state_q == HALT);
`ifdef PC_GEN_TRAP_EN
    assign trap     = (state_q == TRAP);
`else
    assign trap     = 1'b0;
`endif

    pc_target_mux #(.ADDR_W(ADDR_W)) u_mux (
        .pc_i           (pc_q),
        .pc_plus4_i     (pc_plus4),
        .branch_taken_i (branch_taken),
        .branch_imm_i   (branch_imm),
        .jump_i         (jump),
        .jump_idx_i     (jump_idx),
        .jump_reg_i     (jump_reg),
        .reg_target_i   (reg_target),
        .target_o       (target)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (pc_q >= HALT_ADDR) begin
                    state_d = HALT;
                    pc_d    = HALT_ADDR;
                end else if (!stall) begin
`ifdef PC_GEN_TRAP_EN
                    if (target[1:0] != 2'b00) begin
                        state_d = TRAP;
                        pc_d    = TRAP_VEC;
                    end else begin
                        pc_d = target;
                    end
`else
                    pc_d = target & ~ADDR_W'(3);
`endif
                end
            end
            HALT: begin
                if (resume) begin
                    state_d = RUN;
                    pc_d    = RESET_VEC;
                end
            end
            // Trap handler entry is consumed during the TRAP cycle; RUN resumes after it.
            TRAP: begin
                state_d = RUN;
                pc_d    = TRAP_VEC + ADDR_W'(4);
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen with default parameters.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_imm;
    logic        jump;
    logic [25:0] jump_idx;
    logic        jump_reg;
    logic [31:0] reg_target;
    logic        resume;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_valid;
    logic        halted;
    logic        trap;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    pc_gen dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jump         (jump),
        .jump_idx     (jump_idx),
        .jump_reg     (jump_reg),
        .reg_target   (reg_target),
        .resume       (resume),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .pc_valid     (pc_valid),
        .halted       (halted),
        .trap         (trap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall        = 1'b0;
        branch_taken = 1'b0;
        branch_imm   = '0;
        jump         = 1'b0;
        jump_idx     = '0;
        jump_reg     = 1'b0;
        reg_target   = '0;
        resume       = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        #2;
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc4", pc_plus4, 32'h4);
        chk("rst_valid", {31'b0, pc_valid}, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);
        chk("rst_trap", {31'b0, trap}, 32'h0);
        #5 rst = 1'b0;
        #1;
        chk("boot_valid", {31'b0, pc_valid}, 32'h0);

        // BOOT -> RUN, pc held at reset vector
        step();
        chk("run_pc0", pc, 32'h0);
        chk("run_valid0", {31'b0, pc_valid}, 32'h1);
        for (int i = 1; i <= 16; i++) begin
            step();
            chk($sformatf("seq_pc%0d", i), pc, 32'(4 * i));
            chk($sformatf("seq_valid%0d", i), {31'b0, pc_valid}, 32'h1);
        end

        // pc = 64: halt regardless of stall/jump
        stall = 1'b1; jump = 1'b1; jump_idx = 26'd5;
        step();
        chk("halt_pc", pc, 32'd64);
        chk("halt_halted", {31'b0, halted}, 32'h1);
        chk("halt_valid", {31'b0, pc_valid}, 32'h0);
        idle_inputs();
        step();
        chk("halt_hold_pc", pc, 32'd64);
        chk("halt_hold_halted", {31'b0, halted}, 32'h1);

        resume = 1'b1;
        step();
        resume = 1'b0;
        chk("resume_pc", pc, 32'h0);
        chk("resume_valid", {31'b0, pc_valid}, 32'h1);
        chk("resume_halted", {31'b0, halted}, 32'h0);

        // resume outside HALT has no effect
        resume = 1'b1;
        step();
        resume = 1'b0;
        chk("resume_run_pc", pc, 32'h4);
        step();
        chk("pc8", pc, 32'h8);

        // priority: jump_reg wins over jump and branch
        jump_reg = 1'b1; reg_target = 32'h20;
        jump = 1'b1; jump_idx = 26'd5;
        branch_taken = 1'b1; branch_imm = 32'd3;
        step();
        chk("prio_jr", pc, 32'h20);
        idle_inputs();

        jump = 1'b1; jump_idx = 26'd4; branch_taken = 1'b1; branch_imm = 32'd3;
        step();
        chk("prio_j", pc, 32'd16);
        idle_inputs();

        branch_taken = 1'b1; branch_imm = 32'hFFFF_FFFE;
        step();
        chk("br_neg", pc, 32'd8);
        idle_inputs();

        jump = 1'b1; jump_idx = 26'd4;
        step();
        chk("jump16", pc, 32'd16);
        idle_inputs();

        branch_taken = 1'b1; branch_imm = 32'd3;
        step();
        chk("br_pos", pc, 32'd28);
        idle_inputs();

        jump = 1'b1; jump_idx = 26'd3;
        step();
        chk("jump12", pc, 32'd12);

        // stall holds pc with a pending jump
        jump_idx = 26'd10;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stall_pc%0d", i), pc, 32'd12);
            chk($sformatf("stall_valid%0d", i), {31'b0, pc_valid}, 32'h1);
        end
        stall = 1'b0;
        step();
        chk("stall_release", pc, 32'd40);
        idle_inputs();

        // wrap-around below zero
        branch_taken = 1'b1; branch_imm = 32'hFFFF_FFF5;
        step();
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc_plus4, 32'h0);
        idle_inputs();
        stall = 1'b1; jump = 1'b1;
        step();
        chk("wrap_halt_pc", pc, 32'd64);
        chk("wrap_halted", {31'b0, halted}, 32'h1);
        idle_inputs();

        resume = 1'b1;
        step();
        resume = 1'b0;
        chk("resume2_pc", pc, 32'h0);

        // misaligned register target
        jump_reg = 1'b1; reg_target = 32'h22;
        step();
        idle_inputs();
`ifdef PC_GEN_TRAP_EN
        chk("trap_pc", pc, 32'h80);
        chk("trap_flag", {31'b0, trap}, 32'h1);
        chk("trap_valid", {31'b0, pc_valid}, 32'h0);
        step();
        chk("trap_exit_pc", pc, 32'h84);
        chk("trap_exit_flag", {31'b0, trap}, 32'h0);
        chk("trap_exit_valid", {31'b0, pc_valid}, 32'h1);
`else
        chk("align_pc", pc, 32'h20);
        chk("align_trap", {31'b0, trap}, 32'h0);
        chk("align_valid", {31'b0, pc_valid}, 32'h1);
`endif

        // asynchronous reset mid-cycle during RUN
        #2 rst = 1'b1;
        #1;
        chk("async_rst_pc", pc, 32'h0);
        chk("async_rst_valid", {31'b0, pc_valid}, 32'h0);
        chk("async_rst_halted", {31'b0, halted}, 32'h0);
        step();
        chk("rst_held_pc", pc, 32'h0);
        rst = 1'b0;
        step();
        chk("rerun_pc0", pc, 32'h0);
        chk("rerun_valid", {31'b0, pc_valid}, 32'h1);
        step();
        chk("rerun_pc4", pc, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
